// File: rtl/sse_feeder.sv
// Operand buffer and sequencer feeding the sum-of-squared-error accumulator:
// loads A/B pairs from a host, streams them on request, captures the result.
module sse_feeder #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [31:0]                wr_a,
    input  logic [31:0]                wr_b,
    input  logic                       go,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [31:0]                result,
    output logic                       sse_rst,
    output logic [31:0]                A,
    output logic [31:0]                B,
    output logic                       stop,
    input  logic                       sse_next,
    input  logic                       sse_ready,
    input  logic [31:0]                sse_y
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, START, STREAM, DRAIN} state_t;

    state_t          state;
    logic [31:0]     mem_a [DEPTH];
    logic [31:0]     mem_b [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   nxt_ptr;
    logic [CW-1:0]   last;
    logic [TW-1:0]   wdog;
    logic            wr_ok;

    assign full    = (count == CW'(DEPTH));
    assign last    = count - CW'(1);
    assign nxt_ptr = rd_ptr + 1'b1;
    assign wr_ok   = (state == IDLE) && wr_en && !full;

    // Buffer storage carries no reset; stale entries are unreachable once count clears.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_a[count[AW-1:0]] <= wr_a;
            mem_b[count[AW-1:0]] <= wr_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            rd_ptr  <= '0;
            wdog    <= '0;
            A       <= '0;
            B       <= '0;
            stop    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            result  <= '0;
            sse_rst <= 1'b1;
        end else begin
            done    <= 1'b0;
            sse_rst <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_ok)
                        count <= count + 1'b1;
                    if (go && count != '0) begin
                        state   <= START;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                        rd_ptr  <= '0;
                        A       <= mem_a[0];
                        B       <= mem_b[0];
                        sse_rst <= 1'b1;
                    end
                end
                START: state <= STREAM;
                STREAM: begin
                    if (sse_next) begin
                        if ({1'b0, rd_ptr} == last) begin
                            stop  <= 1'b1;
                            wdog  <= '0;
                            state <= DRAIN;
                        end else begin
                            rd_ptr <= nxt_ptr;
                            A      <= mem_a[nxt_ptr];
                            B      <= mem_b[nxt_ptr];
                        end
                    end
                end
                DRAIN: begin
                    // A ready result takes priority over a simultaneous watchdog expiry.
                    if (sse_ready) begin
                        result <= sse_y;
                        done   <= 1'b1;
                        stop   <= 1'b0;
                        busy   <= 1'b0;
                        count  <= '0;
                        state  <= IDLE;
                    end else if (wdog == TW'(TIMEOUT - 1)) begin
                        err    <= 1'b1;
                        stop   <= 1'b0;
                        busy   <= 1'b0;
                        count  <= '0;
                        state  <= IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sse_feeder.sv
// Directed self-checking bench for sse_feeder with a small buffer and short watchdog.
module tb_sse_feeder;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst, wr_en, go, sse_next, sse_ready;
    logic [31:0] wr_a, wr_b, sse_y;
    logic        full, busy, done, err, sse_rst, stop;
    logic [2:0]  count;
    logic [31:0] result, A, B;

    int n_checks = 0;
    int n_fail   = 0;

    sse_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_a(wr_a), .wr_b(wr_b), .go(go),
        .full(full), .count(count), .busy(busy), .done(done), .err(err),
        .result(result), .sse_rst(sse_rst), .A(A), .B(B), .stop(stop),
        .sse_next(sse_next), .sse_ready(sse_ready), .sse_y(sse_y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_pair(input logic [31:0] a, input logic [31:0] b);
        wr_en = 1'b1; wr_a = a; wr_b = b;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_next();
        sse_next = 1'b1;
        tick();
        sse_next = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; go = 1'b0; sse_next = 1'b0; sse_ready = 1'b0;
        wr_a = '0; wr_b = '0; sse_y = '0;

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_sse_rst", {31'b0, sse_rst}, 32'd1);
        end
        check("rst_A", A, 32'h0);
        check("rst_B", B, 32'h0);
        check("rst_flags", {26'b0, stop, busy, done, err, full, 1'b0}, 32'h0);
        check("rst_count", {29'b0, count}, 32'd0);
        check("rst_result", result, 32'h0);
        rst = 1'b0;
        tick();
        check("rst_release", {31'b0, sse_rst}, 32'd0);

        // Three-pair run
        write_pair(32'h3F800000, 32'h3F000000);
        write_pair(32'h40000000, 32'h3F800000);
        write_pair(32'h40400000, 32'h3F800000);
        check("load3_count", {29'b0, count}, 32'd3);
        check("load3_full", {31'b0, full}, 32'd0);
        go = 1'b1; tick(); go = 1'b0;
        check("go_sse_rst", {31'b0, sse_rst}, 32'd1);
        check("go_busy", {31'b0, busy}, 32'd1);
        check("go_A0", A, 32'h3F800000);
        check("go_B0", B, 32'h3F000000);
        tick();
        check("start_sse_rst", {31'b0, sse_rst}, 32'd0);
        pulse_next();
        check("p1_A", A, 32'h40000000);
        check("p1_B", B, 32'h3F800000);
        check("p1_stop", {31'b0, stop}, 32'd0);
        sse_next = 1'b1;
        tick();
        check("p2_A", A, 32'h40400000);
        check("p2_B", B, 32'h3F800000);
        tick();
        sse_next = 1'b0;
        check("p3_stop", {31'b0, stop}, 32'd1);
        check("p3_A_hold", A, 32'h40400000);
        pulse_next();
        check("drain_A_hold", A, 32'h40400000);
        check("drain_stop_hold", {31'b0, stop}, 32'd1);
        sse_ready = 1'b1; sse_y = 32'h40A80000;
        tick();
        sse_ready = 1'b0; sse_y = '0;
        check("ready_done", {31'b0, done}, 32'd1);
        check("ready_result", result, 32'h40A80000);
        check("ready_flags", {29'b0, busy, stop, err}, 32'd0);
        check("ready_count", {29'b0, count}, 32'd0);
        tick();
        check("done_pulse", {31'b0, done}, 32'd0);

        // go with empty buffer
        go = 1'b1; tick(); go = 1'b0;
        check("empty_go_busy", {31'b0, busy}, 32'd0);
        check("empty_go_sse_rst", {31'b0, sse_rst}, 32'd0);

        // Overfill: DEPTH+2 writes
        for (int i = 0; i < DEPTH + 2; i++)
            write_pair(32'h1000 + i, 32'h2000 + i);
        check("over_full", {31'b0, full}, 32'd1);
        check("over_count", {29'b0, count}, DEPTH);
        go = 1'b1; tick(); go = 1'b0;
        tick();
        for (int i = 1; i < DEPTH; i++) pulse_next();
        check("over_lastA", A, 32'h1000 + DEPTH - 1);
        check("over_lastB", B, 32'h2000 + DEPTH - 1);
        pulse_next();
        check("wd_stop", {31'b0, stop}, 32'd1);

        // Watchdog with no ready
        for (int i = 1; i < TIMEOUT; i++) tick();
        check("wd_err_early", {31'b0, err}, 32'd0);
        tick();
        check("wd_err", {31'b0, err}, 32'd1);
        check("wd_done", {31'b0, done}, 32'd0);
        check("wd_flags", {30'b0, busy, stop}, 32'd0);
        check("wd_count", {29'b0, count}, 32'd0);
        check("wd_result", result, 32'h40A80000);

        // New run clears err, then reset mid-stream at rd_ptr=2
        write_pair(32'hAAAA0000, 32'hBBBB0000);
        write_pair(32'hAAAA0001, 32'hBBBB0001);
        write_pair(32'hAAAA0002, 32'hBBBB0002);
        go = 1'b1; tick(); go = 1'b0;
        check("err_cleared", {31'b0, err}, 32'd0);
        tick();
        pulse_next();
        pulse_next();
        check("mid_A2", A, 32'hAAAA0002);
        wr_en = 1'b1; go = 1'b1; wr_a = 32'hDEAD; wr_b = 32'hBEEF;
        tick();
        wr_en = 1'b0; go = 1'b0;
        check("busy_wr_count", {29'b0, count}, 32'd3);
        check("busy_go_norestart", {31'b0, sse_rst}, 32'd0);
        check("busy_go_A", A, 32'hAAAA0002);
        rst = 1'b1; tick(); rst = 1'b0;
        check("midrst_count", {29'b0, count}, 32'd0);
        check("midrst_sse_rst", {31'b0, sse_rst}, 32'd1);
        check("midrst_AB", A | B, 32'h0);
        check("midrst_flags", {30'b0, stop, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
